// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder: FSM state encoding,
// nibble width, and nibble count derivation.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder built from full-adder cells; also exposes
// the carry into bit 3 so callers can derive two's-complement overflow.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder sequenced one nibble per cycle through a single 4-bit stage.
// Optional overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// ADD     | one nibble summed per cycle, carry held in carry_reg
// DONE    | result presented, held until out_ready
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  import nibble_serial_adder_pkg::*;

  localparam int NIB = nib_count(WIDTH);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_t state, next_state;

  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [IW-1:0]    idx;
  logic             last_nib;

  logic [3:0] a_nib, b_nib, s_nib;
  logic       co_nib;

  assign last_nib = (idx == IW'(NIB - 1));

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic c3_nib;
  logic ovf_reg;
`else
  logic c3_unused;
`endif

  nibble_add4 u_add4 (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_reg),
    .s  (s_nib),
    .co (co_nib),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .c3 (c3_nib)
`else
    .c3 (c3_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Outputs are decoded from state only, so no combinational path from the
  // handshake inputs reaches in_ready or out_valid.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_ADD;
      end
      ST_ADD: begin
        busy = 1'b1;
        if (last_nib) next_state = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
          end
        end
        ST_ADD: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
          end
          carry_reg <= co_nib;
          idx       <= idx + IW'(1);
          if (last_nib) begin
            cout_reg <= co_nib;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_reg  <= c3_nib ^ co_nib;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16); overflow
// checks are active when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_chk = 0;
  int n_bad = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands, checks latency, result, then hands the result off.
  task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic [15:0] es, input logic ec, input logic eo);
    int cnt;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = ~bv; cin = ~cv;
    chk("busy_add", 32'(busy), 32'd1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk("latency", 32'(cnt), 32'd4);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) chk("ovf_arg", 32'(eo), 32'd0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_add(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // back-pressure: result frozen, new operands ignored
    @(negedge clk);
    in_valid = 1'b1; a = 16'h00F0; b = 16'h0F10; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0]; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_sum", 32'(sum), 32'h1000);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_handoff_valid", 32'(out_valid), 32'd0);
    chk("bp_handoff_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_single_handoff", 32'(busy), 32'd0);

    // reset during the second ADD cycle
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_partial", 32'(sum), 32'h0003);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    run_add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
